// File: rtl/ram_pkg.sv
// Shared widths and types for the 16x4 data RAM of the 4-bit computer.
// Optional feature macro used by ram_16x4: RAM_CLEAR_ON_RESET_EN.
package ram_pkg;

  localparam int DATA_W = 4;            // word width (accumulator width)
  localparam int ADDR_W = 4;            // address width
  localparam int DEPTH  = 2 ** ADDR_W;  // derived word count, not overridable

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_16x4_ff_reg.sv
// Parameterised-width D register with enable and synchronous active-high
// reset to zero. Used for the address, data and control input stages.
module ff_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture i_d on enabled edges; synchronous reset has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its sources, independent of block order.
    if (rst)
      r_q <= '0;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule : ff_reg

// File: rtl/ram_16x4.sv
// 16-word x 4-bit data RAM with registered address, data and control inputs.
// The core acts on the buffered inputs one clock after presentation; the
// read port is combinational from the buffers and the array, with no bypass.
// Optional feature: define RAM_CLEAR_ON_RESET_EN to have a reset edge also
// clear all 16 words; otherwise the array holds its contents through reset.
module ram_16x4
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addrIN,
  input  logic [DATA_W-1:0] dataIN,
  output logic [DATA_W-1:0] dataOut
);

  addr_t       w_addr_buf;
  word_t       w_data_buf;
  logic [1:0]  w_ctrl_buf;   // {csBuf, weBuf}
  logic        w_cs_buf;
  logic        w_we_buf;
  logic        w_do_write;

  word_t       r_mem [DEPTH];

  // Input stage: all four inputs are captured on every non-reset edge.
  ff_reg #(.W(ADDR_W)) u_addr_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (addrIN),
    .o_q  (w_addr_buf)
  );

  ff_reg #(.W(DATA_W)) u_data_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (dataIN),
    .o_q  (w_data_buf)
  );

  ff_reg #(.W(2)) u_ctrl_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  ({CS, write_en}),
    .o_q  (w_ctrl_buf)
  );

  assign w_cs_buf   = w_ctrl_buf[1];
  assign w_we_buf   = w_ctrl_buf[0];
  assign w_do_write = w_cs_buf & w_we_buf;

`ifdef RAM_CLEAR_ON_RESET_EN
  // Array update: reset wipes every word, otherwise a selected write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_do_write) begin
      r_mem[w_addr_buf] <= w_data_buf;
    end
  end
`else
  // Array update: a selected write lands unless reset suppresses it.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term, so it maps onto plain RAM cells;
    // reset only blocks the write, and unwritten words power up unknown.
    if (!rst && w_do_write)
      r_mem[w_addr_buf] <= w_data_buf;
  end
`endif

  // Read port: deselected chip drives zero; a read is returned during writes
  // too and shows the pre-write word until the write edge has passed.
  always_comb begin
    dataOut = '0;
    if (w_cs_buf)
      dataOut = r_mem[w_addr_buf];
  end

endmodule : ram_16x4

// File: tb/tb_ram_16x4.sv
// Directed bench for ram_16x4: a vector table for reset, basic write/read,
// chip-select gating and read-during-write, then hand-written sequences for
// the full sweep and reset asserted on a write edge.
module tb_ram_16x4;

  logic       clk;
  logic       rst;
  logic       CS;
  logic       write_en;
  logic [3:0] addrIN;
  logic [3:0] dataIN;
  logic [3:0] dataOut;

  int n_vec;
  int n_err;

  ram_16x4 dut (
    .clk      (clk),
    .rst      (rst),
    .CS       (CS),
    .write_en (write_en),
    .addrIN   (addrIN),
    .dataIN   (dataIN),
    .dataOut  (dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rst;
    logic       cs;
    logic       we;
    logic [3:0] addr;
    logic [3:0] data;
    logic       chk;
    logic [3:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dataOut=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic w,
                       input logic [3:0] a, input logic [3:0] d);
    rst      = r;
    CS       = c;
    write_en = w;
    addrIN   = a;
    dataIN   = d;
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //                rst   cs    we    addr  data   chk   exp
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  1'b1, 4'd0};   // reset edge 1
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  1'b1, 4'd0};   // reset edge 2
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd0, 4'd6,  1'b0, 4'd0};   // write mem[0]=6
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'd1, 4'd9,  1'b0, 4'd0};   // write mem[1]=9
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0,  1'b1, 4'd9};   // read 1
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  1'b1, 4'd6};   // read 0 unchanged
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd2, 4'd3,  1'b0, 4'd0};   // write mem[2]=3
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd5,  1'b1, 4'd0};   // CS=0: output 0
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd0,  1'b1, 4'd3};   // mem[2] kept 3
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'd3, 4'd4,  1'b0, 4'd0};   // write mem[3]=4
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd3, 4'd12, 1'b1, 4'd4};   // old word first
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd3, 4'd12, 1'b1, 4'd12};  // new word after
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0,  1'b1, 4'd12};  // read back

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].rst, vecs[v].cs, vecs[v].we, vecs[v].addr, vecs[v].data);
      step();
      if (vecs[v].chk)
        check($sformatf("vec%0d", v), dataOut, vecs[v].exp);
    end

    // Full sweep: mem[i] = 15-i, then read back in order.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'(i), 4'(15 - i));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'(i), 4'd0);
      step();
      check($sformatf("sweep%0d", i), dataOut, 4'(15 - i));
    end

    // Reset on the edge where weBuf=1, addr=1, data=7: write is suppressed.
    drive(1'b0, 1'b1, 1'b1, 4'd1, 4'd9);
    step();
    drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
    step();
    check("restore1", dataOut, 4'd9);
    drive(1'b0, 1'b1, 1'b1, 4'd1, 4'd7);
    step();
    drive(1'b1, 1'b1, 1'b1, 4'd1, 4'd7);
    step();
    check("rst_mid_out", dataOut, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
    step();
`ifdef RAM_CLEAR_ON_RESET_EN
    check("rst_mid_mem1", dataOut, 4'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'(i), 4'd0);
      step();
      check($sformatf("clr%0d", i), dataOut, 4'd0);
    end
`else
    check("rst_mid_mem1", dataOut, 4'd9);
    // Other words survive reset untouched.
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step();
    check("rst_hold0", dataOut, 4'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ram_16x4
